// File: rtl/async_load_pkg.sv
// Shared types and helpers for the async-load sequencer.
// State encoding and counter sizing live here.
package async_load_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    LOAD,
    HOLD
  } state_t;

  // Width of the shared phase counter
  function automatic int cnt_width(int pulse, int hold);
    int m;
    m = (pulse > hold) ? pulse : hold;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/myff.sv
// Single flip-flop with asynchronous load of rval while arst is high.
// Forms one bit of the bank downstream of async_load_ctrl.
module myff (
  input  logic clk,
  input  logic arst,
  input  logic rval,
  input  logic d,
  output logic q
);

  logic q_r;

  // Capture d on clk, or track rval while the load strobe is high
  always_ff @(posedge clk or posedge arst) begin
    if (arst) q_r <= rval;
    else      q_r <= d;
  end

  assign q = arst ? rval : q_r;

endmodule

// File: rtl/async_load_ctrl.sv
// Sequencer for the async-load pins of a flip-flop bank.
// Stages a load value and emits a registered load pulse with setup/hold.
module async_load_ctrl
  import async_load_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               PULSE     = 2,
  parameter int               HOLD      = 1
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic             load_req,
  output logic [WIDTH-1:0] lval,
  output logic             load,
  output logic             busy,
  output logic             done
);

  localparam int CW = cnt_width(PULSE, HOLD);
  localparam logic [CW-1:0] P_LAST = CW'(PULSE - 1);
  localparam logic [CW-1:0] H_LAST =
    CW'((HOLD > 0) ? HOLD - 1 : 0);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] lval_q, lval_d;
  logic             load_q, load_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rdy_q, rdy_d;

  // Next state, counter, staged value and look-ahead outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lval_d  = lval_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (cfg_valid) begin
          lval_d  = cfg_data;
          state_d = SETUP;
        end else if (load_req) begin
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = LOAD;
      end
      LOAD: begin
        if (cnt_q == P_LAST) begin
          cnt_d   = '0;
          state_d = (HOLD == 0) ? IDLE
                                : async_load_pkg::HOLD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      async_load_pkg::HOLD: begin
        if (cnt_q == H_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    load_d = (state_d == LOAD);
    busy_d = (state_d != IDLE);
    rdy_d  = (state_d == IDLE);
    done_d =
      ((HOLD == 0) && (state_d == LOAD)
        && (cnt_d == P_LAST)) ||
      ((HOLD > 0) && (state_d == async_load_pkg::HOLD)
        && (cnt_d == H_LAST));
  end

  // State and output registers; reset forces a load of RESET_VAL
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      lval_q  <= RESET_VAL;
      load_q  <= 1'b1;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lval_q  <= lval_d;
      load_q  <= load_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
    end
  end

  assign lval      = lval_q;
  assign load      = load_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_ready = rdy_q;

endmodule

// File: tb/tb_async_load_ctrl.sv
// Scoreboard bench for async_load_ctrl driving an 8-bit myff bank.
// Driver keeps a sequence-level model; monitor checks on each done.
module tb_async_load_ctrl;

  localparam int         W  = 8;
  localparam logic [7:0] RV = 8'hA5;
  localparam int         P  = 2;
  localparam int         H  = 1;

  typedef struct {
    logic [7:0] val;
    int         len;
  } exp_t;

  logic         clk = 1'b0;
  logic         arst;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [W-1:0] cfg_data;
  logic         load_req;
  logic [W-1:0] lval;
  logic         load;
  logic         busy;
  logic         done;

  logic         force_ff;
  logic [W-1:0] bank_d;
  logic [W-1:0] bank_q;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         rem = 0;
  logic [7:0] staged = RV;

  always #5 clk = ~clk;

  async_load_ctrl #(
    .WIDTH    (W),
    .RESET_VAL(RV),
    .PULSE    (P),
    .HOLD     (H)
  ) dut (
    .clk      (clk),
    .arst     (arst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_data (cfg_data),
    .load_req (load_req),
    .lval     (lval),
    .load     (load),
    .busy     (busy),
    .done     (done)
  );

  assign bank_d = force_ff ? 8'hFF : bank_q;

  for (genvar i = 0; i < W; i++) begin : g_bank
    myff u_ff (
      .clk (clk),
      .arst(load),
      .rval(lval[i]),
      .d   (bank_d[i]),
      .q   (bank_q[i])
    );
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Sequence-level model: an accepted request makes the block
  // busy for 1+P+H cycles and loads the chosen value once.
  task automatic step(input logic v,
                      input logic [7:0] dat,
                      input logic r);
    chk("cfg_ready", {31'd0, cfg_ready},
        {31'd0, rem == 0});
    if (rem > 0) begin
      rem--;
    end else if (v || r) begin
      if (v) staged = dat;
      sb.push_back('{staged, 1 + P + H});
      rem = 1 + P + H;
    end
    cfg_valid = v;
    cfg_data  = dat;
    load_req  = r;
  endtask

  task automatic cycle(input logic v,
                       input logic [7:0] dat,
                       input logic r);
    @(negedge clk);
    step(v, dat, r);
  endtask

  task automatic reset_checks();
    chk("rst_lval", {24'd0, lval}, {24'd0, RV});
    chk("rst_load", {31'd0, load}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_ready", {31'd0, cfg_ready}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_bank", {24'd0, bank_q}, {24'd0, RV});
  endtask

  task automatic release_reset();
    @(negedge clk);
    arst = 1'b0;
    sb.push_back('{RV, P + H});
    rem = P + H;
    step(1'b0, 8'h00, 1'b0);
  endtask

  // Monitor: per-sequence checks on done, lval stability while busy
  initial begin : monitor
    int         bcnt;
    int         lcnt;
    logic       pbusy;
    logic [7:0] plval;
    exp_t       e;
    bcnt  = 0;
    lcnt  = 0;
    pbusy = 1'b0;
    plval = '0;
    forever begin
      @(negedge clk);
      #1;
      if (arst) begin
        bcnt  = 0;
        lcnt  = 0;
        pbusy = 1'b0;
      end else begin
        if (busy) bcnt++;
        if (load) lcnt++;
        if (pbusy && busy)
          chk("lval_stable", {24'd0, lval},
              {24'd0, plval});
        if (done) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got 1 expected 0");
          end else begin
            e = sb.pop_front();
            chk("done_lval", {24'd0, lval}, {24'd0, e.val});
            chk("done_bank", {24'd0, bank_q},
                {24'd0, e.val});
            chk("seq_len", bcnt, e.len);
            chk("pulse_len", lcnt, P);
          end
          bcnt = 0;
          lcnt = 0;
        end
        pbusy = busy;
        plval = lval;
      end
    end
  end

  initial begin : driver
    arst      = 1'b1;
    cfg_valid = 1'b0;
    cfg_data  = '0;
    load_req  = 1'b0;
    force_ff  = 1'b0;

    // 1: reset holds the bank at RESET_VAL
    #1;
    reset_checks();
    repeat (2) @(negedge clk);
    release_reset();
    repeat (3) cycle(1'b0, 8'h00, 1'b0);

    // 2: new config value
    cycle(1'b1, 8'h3C, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    #1;
    chk("setup_load", {31'd0, load}, 32'd0);
    chk("setup_lval", {24'd0, lval}, 32'h3C);
    repeat (4) cycle(1'b0, 8'h00, 1'b0);

    // 3: corrupt the bank, then reload staged value
    @(negedge clk);
    force_ff = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    force_ff = 1'b0;
    chk("bank_forced", {24'd0, bank_q}, 32'hFF);
    step(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    repeat (5) cycle(1'b0, 8'h00, 1'b0);

    // 4: cfg and load_req together -> one sequence
    cycle(1'b1, 8'h11, 1'b1);
    repeat (5) cycle(1'b0, 8'h00, 1'b0);

    // 5: cfg offered mid-LOAD is ignored
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'h77, 1'b0);
    repeat (4) cycle(1'b0, 8'h00, 1'b0);

    // random traffic
    repeat (400)
      cycle($urandom_range(0, 3) == 0, 8'($urandom),
            $urandom_range(0, 4) == 0);
    while (rem > 0) cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);

    // 6: reset during HOLD of a 3C load
    cycle(1'b1, 8'h3C, 1'b0);
    repeat (3) cycle(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    #2;
    arst      = 1'b1;
    cfg_valid = 1'b0;
    load_req  = 1'b0;
    #1;
    reset_checks();
    sb.delete();
    @(negedge clk);
    release_reset();
    repeat (6) cycle(1'b0, 8'h00, 1'b0);

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
